imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 129 ++++++++++++
 tb/tb_imem_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory controller: fixed-latency fetch port with NOP/err substitution
// for misaligned or out-of-range addresses, plus a preload write port.
module imem_ctrl #(
  parameter int bits    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            proc_req,
  input  logic [bits-1:0] addr,
  output logic            mem_rdy,
  output logic            valid,
  output logic [bits-1:0] rdata,
  output logic            err,
  input  logic            prog_we,
  input  logic [bits-1:0] prog_addr,
  input  logic [bits-1:0] prog_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [bits-1:0] NOP = bits'(32'h0000_0013);
  localparam logic [3:0] LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [bits-1:0] addr_q, addr_d;
  logic [bits-1:0] rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic [bits-1:0] mem [DEPTH];

  logic            accept;
  logic            capture;
  logic [bits-1:0] cap_addr;
  logic [bits-1:0] cap_word;
  logic            cap_bad;
  logic [bits-1:0] wr_word;
  logic            wr_ok;

  // Ready is gated by reset directly so it is low while reset is held and high
  // in the very first cycle after release.
  assign mem_rdy = rst && (state_q != WAIT);
  assign accept  = proc_req && mem_rdy;

  assign valid = valid_q;
  assign rdata = rdata_q;
  assign err   = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    capture  = 1'b0;
    cap_addr = addr_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          addr_d = addr;
          if (LATENCY == 0) begin
            // Zero latency: the word is captured on the accept edge itself.
            state_d  = RESP;
            capture  = 1'b1;
            cap_addr = addr;
          end else begin
            state_d = WAIT;
            cnt_d   = LOAD;
          end
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    cap_word = cap_addr >> 2;
    cap_bad  = (cap_addr[1:0] != 2'b00) || ((cap_word >> AW) != '0);

    if (capture) begin
      valid_d = 1'b1;
      err_d   = cap_bad;
      rdata_d = cap_bad ? NOP : mem[cap_word[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so preloaded code survives reset.
  assign wr_word = prog_addr >> 2;
  assign wr_ok   = prog_we && ((wr_word >> AW) == '0);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_word[AW-1:0]] <= prog_wdata;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed scoreboard bench for imem_ctrl: one LATENCY=2 instance and one
// LATENCY=0 instance sharing clock, reset and the preload port.
module tb_imem_ctrl;

  localparam int W = 32;
  localparam int D = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         prog_we;
  logic [W-1:0] prog_addr;
  logic [W-1:0] prog_wdata;

  logic         req2, rdy2, valid2, err2;
  logic [W-1:0] addr2, rdata2;
  logic         req0, rdy0, valid0, err0;
  logic [W-1:0] addr0, rdata0;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [31:0] mdl [D];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  imem_ctrl #(.bits(W), .DEPTH(D), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .proc_req(req2), .addr(addr2),
    .mem_rdy(rdy2), .valid(valid2), .rdata(rdata2), .err(err2),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  imem_ctrl #(.bits(W), .DEPTH(D), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .proc_req(req0), .addr(addr0),
    .mem_rdy(rdy0), .valid(valid0), .rdata(rdata0), .err(err0),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expOf(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b00 || (a >> 2) >= D) begin
      e.data = 32'h0000_0013;
      e.err  = 1'b1;
    end else begin
      e.data = mdl[a[5:2]];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic progWrite(input logic [31:0] a, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    tick();
    prog_we = 1'b0;
    if ((a >> 2) < D) mdl[a[5:2]] = d;
  endtask

  // Present one request to the LATENCY=2 instance for the accept edge only.
  task automatic applyStimulus(input logic [31:0] a);
    req2  = 1'b1;
    addr2 = a;
    q2.push_back(expOf(a));
    tick();
    req2 = 1'b0;
  endtask

  // Scoreboard side: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (valid2 === 1'b1) begin
      checkOutput("dut2_valid_pending", {31'b0, valid2}, {31'b0, q2.size() != 0});
      if (q2.size() != 0) begin
        checkOutput("dut2_rdata", rdata2, q2[0].data);
        checkOutput("dut2_err", {31'b0, err2}, {31'b0, q2[0].err});
        void'(q2.pop_front());
      end
    end
    if (valid0 === 1'b1) begin
      checkOutput("dut0_valid_pending", {31'b0, valid0}, {31'b0, q0.size() != 0});
      if (q0.size() != 0) begin
        checkOutput("dut0_rdata", rdata0, q0[0].data);
        checkOutput("dut0_err", {31'b0, err0}, {31'b0, q0[0].err});
        void'(q0.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    req2 = 1'b0; addr2 = '0; req0 = 1'b0; addr0 = '0;
    for (int i = 0; i < D; i++) mdl[i] = 32'hx;

    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_mem_rdy", {31'b0, rdy2}, 32'd0);
    checkOutput("reset_valid", {31'b0, valid2}, 32'd0);
    checkOutput("reset_err", {31'b0, err2}, 32'd0);
    checkOutput("reset_rdata", rdata2, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkOutput("mem_rdy_after_release", {31'b0, rdy2}, 32'd1);

    $display("[TB] preload");
    progWrite(32'h0, 32'h0050_0093);
    for (int i = 1; i < D; i++) progWrite(32'(i * 4), 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000);
    progWrite(32'(4 * D), 32'hDEAD_BEEF);

    $display("[TB] basic fetch latency 2");
    applyStimulus(32'h0);
    checkOutput("k1_mem_rdy", {31'b0, rdy2}, 32'd0);
    checkOutput("k1_valid", {31'b0, valid2}, 32'd0);
    tick();
    checkOutput("k2_mem_rdy", {31'b0, rdy2}, 32'd0);
    checkOutput("k2_valid", {31'b0, valid2}, 32'd0);
    tick();
    checkOutput("k3_valid", {31'b0, valid2}, 32'd1);
    checkOutput("k3_rdata", rdata2, 32'h0050_0093);
    checkOutput("k3_err", {31'b0, err2}, 32'd0);
    checkOutput("k3_mem_rdy", {31'b0, rdy2}, 32'd1);
    tick();
    checkOutput("k4_valid", {31'b0, valid2}, 32'd0);
    checkOutput("k4_rdata_held", rdata2, 32'h0050_0093);
    checkOutput("k4_mem_rdy", {31'b0, rdy2}, 32'd1);

    $display("[TB] misaligned and out-of-range");
    applyStimulus(32'h2);
    repeat (2) tick();
    checkOutput("misaligned_err", {31'b0, err2}, 32'd1);
    tick();
    checkOutput("err_low_after_resp", {31'b0, err2}, 32'd0);
    applyStimulus(32'(4 * D));
    repeat (2) tick();
    checkOutput("oor_rdata", rdata2, 32'h0000_0013);
    tick();

    $display("[TB] address change during wait");
    applyStimulus(32'h0);
    req2 = 1'b1; addr2 = 32'h8;
    tick();
    req2 = 1'b0;
    tick();
    checkOutput("wait_ignore_rdata", rdata2, 32'h0050_0093);
    tick();

    $display("[TB] back-to-back in RESP");
    applyStimulus(32'h4);
    tick();
    req2 = 1'b1; addr2 = 32'hC;
    q2.push_back(expOf(32'hC));
    tick();
    checkOutput("b2b_valid_in_resp", {31'b0, valid2}, 32'd1);
    checkOutput("b2b_mem_rdy_resp", {31'b0, rdy2}, 32'd1);
    tick();
    req2 = 1'b0;
    checkOutput("b2b_wait_mem_rdy", {31'b0, rdy2}, 32'd0);
    repeat (2) tick();
    checkOutput("b2b_second_valid", {31'b0, valid2}, 32'd1);
    tick();

    $display("[TB] preload collides with capture");
    applyStimulus(32'd20);
    tick();
    prog_we = 1'b1; prog_addr = 32'd20; prog_wdata = 32'h1234_5678;
    tick();
    prog_we = 1'b0;
    mdl[5] = 32'h1234_5678;
    checkOutput("collide_old_data_valid", {31'b0, valid2}, 32'd1);
    tick();
    applyStimulus(32'd20);
    repeat (3) tick();
    checkOutput("collide_new_data", rdata2, 32'h1234_5678);

    $display("[TB] reset mid-wait");
    applyStimulus(32'h8);
    void'(q2.pop_back());
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_mem_rdy", {31'b0, rdy2}, 32'd0);
    checkOutput("abort_valid", {31'b0, valid2}, 32'd0);
    checkOutput("abort_rdata", rdata2, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("abort_no_valid_%0d", i), {31'b0, valid2}, 32'd0);
      tick();
    end
    applyStimulus(32'hC);
    repeat (2) tick();
    checkOutput("refetch_rdata", rdata2, mdl[3]);
    tick();

    $display("[TB] zero latency streaming");
    req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr0 = 32'(i * 4);
      q0.push_back(expOf(addr0));
      checkOutput($sformatf("l0_mem_rdy_%0d", i), {31'b0, rdy0}, 32'd1);
      tick();
      checkOutput($sformatf("l0_valid_%0d", i), {31'b0, valid0}, 32'd1);
      checkOutput($sformatf("l0_rdata_%0d", i), rdata0, mdl[i]);
    end
    req0 = 1'b0;
    tick();
    checkOutput("l0_idle_valid", {31'b0, valid0}, 32'd0);
    tick();

    checkOutput("dut2_queue_drained", 32'(q2.size()), 32'd0);
    checkOutput("dut0_queue_drained", 32'(q0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
